// File: rtl/and_reduce_pkg.sv
// Shared constants, types and elaboration helpers for the pipelined AND-reduction tree.
package and_reduce_pkg;

   localparam int RADIX = 4;

   // Number of radix-4 levels needed to fold n bits down to a single bit.
   function automatic int clog4(input int n);
      int     levels;
      longint span;
      levels = 0;
      span   = 1;
      while (span < n) begin
         span   = span * RADIX;
         levels = levels + 1;
      end
      return levels;
   endfunction

   // Bit offset of level k inside the flattened per-level data vector.
   function automatic int level_offset(input int pad_w, input int k);
      int off;
      int w;
      off = 0;
      w   = pad_w;
      for (int j = 0; j < k; j++) begin
         off = off + w;
         w   = w / RADIX;
      end
      return off;
   endfunction

   typedef struct packed {
      logic valid;
      logic data;
   } stage_rec_t;

endpackage

// File: rtl/and4_stage.sv
// One radix-4 AND level: each group of four adjacent bits folds into one bit, registered with
// its valid flag. The whole stage holds while advance is low.
module and4_stage
   import and_reduce_pkg::*;
#(
   parameter int IN_W = 4
) (
   input  logic                  ck,
   input  logic                  rst,
   input  logic [IN_W-1:0]       data,
   input  logic                  valid,
   input  logic                  advance,
   output logic [IN_W/RADIX-1:0] data_q,
   output logic                  valid_q
);

   localparam int OUT_W = IN_W / RADIX;

   logic [OUT_W-1:0] folded;

   always_comb begin
      folded = '0;
      for (int g = 0; g < OUT_W; g++) begin
         folded[g] = &data[g*RADIX +: RADIX];
      end
   end

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (advance) begin
         data_q  <= folded;
         valid_q <= valid;
      end
   end

endmodule

// File: rtl/and_reduce_pipe.sv
// Pipelined wide-AND reduction with valid/ready on both sides and a saturating zero-result counter.
// Define AND_REDUCE_PIPE_SKID_EN to add a 2-entry skid buffer that makes in_ready a registered signal.
module and_reduce_pipe
   import and_reduce_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
) (
   input  logic             ck,
   input  logic             rst,
   input  logic [WIDTH-1:0] i,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             q,
   output logic             nq,
   output logic             q_valid,
   input  logic             q_ready,
   output logic [CNT_W-1:0] zero_cnt,
   input  logic             cnt_clr
);

   localparam int L     = clog4(WIDTH);
   localparam int PAD_W = 1 << (2 * L);
   localparam int TOT_W = level_offset(PAD_W, L + 1);

   logic [PAD_W-1:0] padded;
   logic [TOT_W-1:0] lvl_data;
   logic [L:0]       lvl_valid;
   logic             advance;
   logic             deliver;
   stage_rec_t       tail;

   // Missing high bits are filled with 1s so they never pull the AND low.
   always_comb begin
      padded            = '1;
      padded[WIDTH-1:0] = i;
   end

   assign lvl_data[PAD_W-1:0] = padded;
   assign lvl_valid[0]        = in_valid;

   for (genvar k = 0; k < L; k++) begin : g_level
      localparam int IN_W    = PAD_W >> (2 * k);
      localparam int IN_OFF  = level_offset(PAD_W, k);
      localparam int OUT_OFF = level_offset(PAD_W, k + 1);

      and4_stage #(.IN_W(IN_W)) u_stage (
         .ck      (ck),
         .rst     (rst),
         .data    (lvl_data[IN_OFF +: IN_W]),
         .valid   (lvl_valid[k]),
         .advance (advance),
         .data_q  (lvl_data[OUT_OFF +: IN_W/RADIX]),
         .valid_q (lvl_valid[k+1])
      );
   end

   assign tail = {lvl_valid[L], lvl_data[TOT_W-1]};

`ifdef AND_REDUCE_PIPE_SKID_EN
   logic       skid_data [2];
   logic [1:0] skid_cnt;
   logic       push;
   logic       pop;

   // The pipeline only moves while the skid has room, so advance depends on skid state alone.
   assign advance = (skid_cnt != 2'd2);
   assign push    = advance && tail.valid;
   assign pop     = q_valid && q_ready;

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         skid_data[0] <= 1'b0;
         skid_data[1] <= 1'b0;
         skid_cnt     <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               skid_data[skid_cnt[0]] <= tail.data;
               skid_cnt               <= skid_cnt + 2'd1;
            end
            2'b01: begin
               skid_data[0] <= skid_data[1];
               skid_cnt     <= skid_cnt - 2'd1;
            end
            2'b11: begin
               // Push needs room and pop needs an entry, so exactly one entry is present here.
               skid_data[0] <= tail.data;
            end
            default: begin
            end
         endcase
      end
   end

   assign q_valid = (skid_cnt != 2'd0);
   assign q       = skid_data[0];
`else
   assign advance = !tail.valid || q_ready;
   assign q_valid = tail.valid;
   assign q       = tail.data;
`endif

   assign in_ready = advance;
   assign nq       = ~q;
   assign deliver  = q_valid && q_ready;

   // Clear wins over a same-cycle counted delivery; the count sticks at all-ones.
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         zero_cnt <= '0;
      end else if (cnt_clr) begin
         zero_cnt <= '0;
      end else if (deliver && !q && (zero_cnt != {CNT_W{1'b1}})) begin
         zero_cnt <= zero_cnt + CNT_W'(1);
      end
   end

endmodule
